// File: rtl/ones_pattern_generator_pkg.sv
// Shared types and helpers for the ones pattern generator.
// Pattern helpers return a wide vector; callers cast down to their own width.
package ones_pattern_generator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_FEATURES = 8;
    localparam int unsigned MAX_FEATURES = 64;
    localparam int unsigned CNT_W        = $clog2(DEF_FEATURES + 1);

    // Smallest vector with k bits set: k ones packed at the bottom.
    function automatic logic [MAX_FEATURES-1:0] first_pattern(input int unsigned k);
        logic [MAX_FEATURES-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        if (k >= MAX_FEATURES) begin
            return '1;
        end
        return (one << k) - one;
    endfunction

    // Largest n-bit vector with k bits set: k ones packed at the top (k <= n).
    function automatic logic [MAX_FEATURES-1:0] last_pattern(input int unsigned k,
                                                             input int unsigned n);
        return first_pattern(k) << (n - k);
    endfunction

endpackage

// File: rtl/ones_pattern_generator_next.sv
// Combinational Gosper step: next larger N-bit value with the same popcount.
// The caller never feeds the final pattern, so the add cannot carry out.
module ones_pattern_next #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x_i,
    output logic [N-1:0] next_o
);

    logic [N-1:0] lowest;
    logic [N-1:0] ripple;
    logic [N-1:0] tail;
    int unsigned  tz;

    // Trailing-zero count, lowest set bit, ripple add, and re-packed tail ones.
    always_comb begin
        tz = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (x_i[i]) begin
                tz = i;
            end
        end
        lowest = x_i & (~x_i + N'(1));
        ripple = x_i + lowest;
        tail   = ((x_i ^ ripple) >> 2) >> tz;
        next_o = ripple | tail;
    end

endmodule

// File: rtl/ones_pattern_generator.sv
// Emits every INPUT_FEATURES-bit vector with exactly K bits set, ascending,
// one per accepted valid/ready beat. All outputs are registered.
// Optional self-check enabled by macro ONES_PATTERN_CHECK_EN: popcount and
// strict ordering of every accepted beat, reported on a sticky error_o.
//
// state    | meaning
// ST_IDLE  | waiting for start_i; features_o holds the final pattern of last run
// ST_RUN   | presenting a beat; advances on valid_o & ready_i, ends after last_o
module ones_pattern_generator
    import ones_pattern_generator_pkg::*;
#(
    parameter int unsigned INPUT_FEATURES = DEF_FEATURES
) (
    input  logic                                  clock_i,
    input  logic                                  reset_i,
    input  logic                                  start_i,
    input  logic [$clog2(INPUT_FEATURES+1)-1:0]   ones_i,
    input  logic                                  ready_i,
    output logic [INPUT_FEATURES-1:0]             features_o,
    output logic                                  valid_o,
    output logic                                  last_o,
    output logic                                  busy_o,
    output logic                                  error_o
);

    localparam int unsigned N  = INPUT_FEATURES;
    localparam int unsigned CW = $clog2(N + 1);

    state_e         state_q, state_d;
    logic [N-1:0]   features_q, features_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  keff_q, keff_d;

    logic [N-1:0]   next_pattern;
    logic [CW-1:0]  keff_in;
    logic           accept;
    logic           start_take;

    ones_pattern_next #(.N(N)) u_next (
        .x_i    (features_q),
        .next_o (next_pattern)
    );

    assign accept     = (state_q == ST_RUN) && valid_q && ready_i;
    assign start_take = (state_q == ST_IDLE) && start_i;
    assign keff_in    = (32'(ones_i) > N) ? CW'(N) : ones_i;

    // Next-state and registered-output logic for the run sequencer.
    always_comb begin
        state_d    = state_q;
        features_d = features_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        keff_d     = keff_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    keff_d     = keff_in;
                    features_d = N'(first_pattern(32'(keff_in)));
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    last_d     = (keff_in == '0) || (32'(keff_in) == N);
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        features_d = next_pattern;
                        last_d     = (next_pattern == N'(last_pattern(32'(keff_q), N)));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset aborts any run in progress.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            features_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            keff_q     <= '0;
        end else begin
            state_q    <= state_d;
            features_q <= features_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            keff_q     <= keff_d;
        end
    end

    assign features_o = features_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign busy_o     = busy_q;

`ifdef ONES_PATTERN_CHECK_EN
    // The checker observes the output port itself so it sees what the consumer sees.
    logic           chk_v_q, chk_v_d;
    logic [CW-1:0]  chk_pop_q, chk_pop_d;
    logic [CW-1:0]  chk_k_q, chk_k_d;
    logic [N-1:0]   chk_feat_q, chk_feat_d;
    logic [N-1:0]   chk_prev_q, chk_prev_d;
    logic           chk_has_prev_q, chk_has_prev_d;
    logic [N-1:0]   prev_feat_q, prev_feat_d;
    logic           has_prev_q, has_prev_d;
    logic           err_q, err_d;
    logic [CW-1:0]  pop;

    // Capture each accepted beat, then judge it one cycle later.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + CW'(features_o[i]);
        end
        chk_v_d        = accept;
        chk_pop_d      = chk_pop_q;
        chk_k_d        = chk_k_q;
        chk_feat_d     = chk_feat_q;
        chk_prev_d     = chk_prev_q;
        chk_has_prev_d = chk_has_prev_q;
        prev_feat_d    = prev_feat_q;
        has_prev_d     = has_prev_q;
        err_d          = err_q;
        if (accept) begin
            chk_pop_d      = pop;
            chk_k_d        = keff_q;
            chk_feat_d     = features_o;
            chk_prev_d     = prev_feat_q;
            chk_has_prev_d = has_prev_q;
            prev_feat_d    = features_o;
            has_prev_d     = 1'b1;
        end
        if (start_take) begin
            has_prev_d = 1'b0;
        end
        if (chk_v_q && ((chk_pop_q != chk_k_q) ||
                        (chk_has_prev_q && (chk_feat_q <= chk_prev_q)))) begin
            err_d = 1'b1;
        end
    end

    // Checker registers; error flag is sticky until reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            chk_v_q        <= 1'b0;
            chk_pop_q      <= '0;
            chk_k_q        <= '0;
            chk_feat_q     <= '0;
            chk_prev_q     <= '0;
            chk_has_prev_q <= 1'b0;
            prev_feat_q    <= '0;
            has_prev_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            chk_v_q        <= chk_v_d;
            chk_pop_q      <= chk_pop_d;
            chk_k_q        <= chk_k_d;
            chk_feat_q     <= chk_feat_d;
            chk_prev_q     <= chk_prev_d;
            chk_has_prev_q <= chk_has_prev_d;
            prev_feat_q    <= prev_feat_d;
            has_prev_q     <= has_prev_d;
            err_q          <= err_d;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ones_pattern_generator.sv
// Self-checking bench: expected pattern lists are built by brute-force
// enumeration of all N-bit values with the requested popcount.
module tb_ones_pattern_generator;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [CW-1:0] ones_i;
    logic          ready_i;
    logic [N-1:0]  features_o;
    logic          valid_o;
    logic          last_o;
    logic          busy_o;
    logic          error_o;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    always #5 clock_i = ~clock_i;

    ones_pattern_generator #(.INPUT_FEATURES(N)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .ones_i     (ones_i),
        .ready_i    (ready_i),
        .features_o (features_o),
        .valid_o    (valid_o),
        .last_o     (last_o),
        .busy_o     (busy_o),
        .error_o    (error_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_feat"},  32'(features_o), 0);
        chk({tag, "_valid"}, 32'(valid_o), 0);
        chk({tag, "_last"},  32'(last_o), 0);
        chk({tag, "_busy"},  32'(busy_o), 0);
        chk({tag, "_err"},   32'(error_o), 0);
    endtask

    // One run of K; ready_pct = chance of ready per cycle; poke = pulse start mid-run;
    // abort_at >= 0 pulls reset while that beat index is on the outputs.
    task automatic do_run(input int k, input int ready_pct, input bit poke, input int abort_at);
        int           keff;
        int           idx;
        int           cyc;
        bit           done;
        bit           rdy;
        bit           hold_chk;
        logic [N-1:0] held;
        logic [N-1:0] tv;
        keff = (k > N) ? N : k;
        exp_q.delete();
        for (int v = 0; v < (1 << N); v++) begin
            tv = v[N-1:0];
            if ($countones(tv) == keff) exp_q.push_back(tv);
        end
        @(negedge clock_i);
        start_i = 1'b1;
        ones_i  = k[CW-1:0];
        ready_i = 1'b0;
        @(negedge clock_i);
        start_i  = 1'b0;
        idx      = 0;
        cyc      = 0;
        done     = 1'b0;
        hold_chk = 1'b0;
        held     = '0;
        while (!done) begin
            if (idx < exp_q.size()) begin
                chk($sformatf("k%0d_valid_%0d", k, idx), 32'(valid_o), 1);
                chk($sformatf("k%0d_busy_%0d", k, idx), 32'(busy_o), 1);
                chk($sformatf("k%0d_feat_%0d", k, idx), 32'(features_o), 32'(exp_q[idx]));
                chk($sformatf("k%0d_last_%0d", k, idx), 32'(last_o),
                    32'(idx == exp_q.size() - 1));
                if (hold_chk) chk($sformatf("k%0d_hold_%0d", k, idx), 32'(features_o), 32'(held));
                if (abort_at >= 0 && idx == abort_at) begin
                    #2 reset_i = 1'b0;
                    #1 chk_all_zero("abort");
                    @(negedge clock_i);
                    reset_i = 1'b1;
                    ready_i = 1'b0;
                    start_i = 1'b0;
                    return;
                end
                rdy      = ($urandom_range(99) < ready_pct);
                ready_i  = rdy;
                hold_chk = !rdy;
                held     = features_o;
                if (poke) begin
                    start_i = ($urandom_range(3) == 0);
                    ones_i  = CW'($urandom_range(N));
                end
                if (rdy) idx++;
            end else begin
                chk($sformatf("k%0d_end_valid", k), 32'(valid_o), 0);
                chk($sformatf("k%0d_end_busy", k), 32'(busy_o), 0);
                chk($sformatf("k%0d_end_feat", k), 32'(features_o),
                    32'(exp_q[exp_q.size() - 1]));
                chk($sformatf("k%0d_end_err", k), 32'(error_o), 0);
                ready_i = 1'b0;
                start_i = 1'b0;
                done    = 1'b1;
            end
            cyc++;
            if (!done && cyc > 2000) begin
                chk($sformatf("k%0d_timeout", k), 32'(cyc), 0);
                done = 1'b1;
            end
            if (!done) @(negedge clock_i);
        end
    endtask

    initial begin
        reset_i = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b0;
        ones_i  = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clock_i);
        reset_i = 1'b1;

        do_run(2, 100, 1'b0, -1);
        do_run(0, 100, 1'b0, -1);
        do_run(8, 100, 1'b0, -1);
        do_run(4, 50, 1'b0, -1);
        do_run(9, 60, 1'b0, -1);
        do_run(3, 70, 1'b1, -1);
        do_run(3, 100, 1'b0, 10);
        do_run(1, 100, 1'b0, -1);
        do_run(5, 30, 1'b0, -1);

`ifdef ONES_PATTERN_CHECK_EN
        begin
            int cyc;
            @(negedge clock_i);
            start_i = 1'b1;
            ones_i  = CW'(2);
            @(negedge clock_i);
            start_i = 1'b0;
            force dut.features_o = 8'h01;
            ready_i = 1'b1;
            @(negedge clock_i);
            release dut.features_o;
            ready_i = 1'b0;
            @(negedge clock_i);
            chk("err_set", 32'(error_o), 1);
            ready_i = 1'b1;
            cyc = 0;
            while (busy_o && cyc < 100) begin
                @(negedge clock_i);
                cyc++;
            end
            ready_i = 1'b0;
            chk("err_drain_busy", 32'(busy_o), 0);
            @(negedge clock_i);
            chk("err_sticky", 32'(error_o), 1);
            #2 reset_i = 1'b0;
            #1 chk("err_cleared", 32'(error_o), 0);
            @(negedge clock_i);
            reset_i = 1'b1;
        end
`endif

        repeat (2) @(negedge clock_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
